// File: rtl/cmd_frame_tx.sv
// ASCII command-frame transmitter: serialises "XPSD" + dir + layer + '0' + slot
// onto a UART byte interface with a start/done handshake, optional inter-byte gap and timeout.
module cmd_frame_tx #(
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [1:0] cmd_layer,
    input  logic [1:0] cmd_slot,
    output logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    // Counter compare points: WAIT spends TIMEOUT_CYCLES-1 clocks before aborting.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dir_q, dir_n;
    logic [1:0]       layer_q, layer_n;
    logic [1:0]       slot_q, slot_n;
    logic [7:0]       tx_data_n;

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic d,
                                              input logic [1:0] l, input logic [1:0] s);
        case (i)
            3'd0:    return 8'h58;
            3'd1:    return 8'h50;
            3'd2:    return 8'h53;
            3'd3:    return 8'h44;
            3'd4:    return d ? 8'h46 : 8'h53;
            3'd5:    return 8'h41 + {6'd0, l};
            3'd6:    return 8'h30;
            default: return 8'h31 + {6'd0, s};
        endcase
    endfunction

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        dir_n   = dir_q;
        layer_n = layer_q;
        slot_n  = slot_q;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_n   = cmd_dir;
                    layer_n = cmd_layer;
                    slot_n  = cmd_slot;
                    idx_n   = '0;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_n   = '0;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n   = idx + 3'd1;
                        state_n = (GAP_CYCLES == 0) ? ST_SEND : ST_GAP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == TO_LAST) state_n = ST_ERR;
                end
            end
            ST_GAP: begin
                cnt_n = cnt + 1'b1;
                if (cnt == GAP_LAST) state_n = ST_SEND;
            end
            default: begin
                idx_n   = '0;
                dir_n   = 1'b0;
                layer_n = '0;
                slot_n  = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so each is high for the whole state cycle.
    always_comb begin
        tx_data_n = tx_data;
        if (state_n == ST_SEND) tx_data_n = frame_byte(idx_n, dir_n, layer_n, slot_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            dir_q      <= 1'b0;
            layer_q    <= '0;
            slot_q     <= '0;
            cmd_ready  <= 1'b1;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            dir_q      <= dir_n;
            layer_q    <= layer_n;
            slot_q     <= slot_n;
            cmd_ready  <= (state_n == ST_IDLE);
            tx_data    <= tx_data_n;
            tx_start   <= (state_n == ST_SEND);
            busy       <= (state_n != ST_IDLE);
            frame_done <= (state_n == ST_DONE);
            frame_err  <= (state_n == ST_ERR);
        end
    end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx: two instances (no gap, 5-clock gap), both with a 20-clock timeout;
// sel routes stimulus to one instance and muxes its outputs back.
module tb_cmd_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [1:0] cmd_layer = '0;
    logic [1:0] cmd_slot = '0;
    logic       tx_done = 1'b0;
    logic       sel = 1'b0;

    logic       cmd_valid_a, tx_done_a, cmd_valid_b, tx_done_b;
    logic       cmd_ready_a, tx_start_a, busy_a, frame_done_a, frame_err_a;
    logic       cmd_ready_b, tx_start_b, busy_b, frame_done_b, frame_err_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       cmd_ready, tx_start, busy, frame_done, frame_err;
    logic [7:0] tx_data;

    assign cmd_valid_a = cmd_valid & ~sel;
    assign tx_done_a   = tx_done & ~sel;
    assign cmd_valid_b = cmd_valid & sel;
    assign tx_done_b   = tx_done & sel;
    assign cmd_ready   = sel ? cmd_ready_b  : cmd_ready_a;
    assign tx_start    = sel ? tx_start_b   : tx_start_a;
    assign tx_data     = sel ? tx_data_b    : tx_data_a;
    assign busy        = sel ? busy_b       : busy_a;
    assign frame_done  = sel ? frame_done_b : frame_done_a;
    assign frame_err   = sel ? frame_err_b  : frame_err_a;

    cmd_frame_tx #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(20), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_dir(cmd_dir),
        .cmd_layer(cmd_layer), .cmd_slot(cmd_slot), .cmd_ready(cmd_ready_a),
        .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_done(tx_done_a), .busy(busy_a),
        .frame_done(frame_done_a), .frame_err(frame_err_a));

    cmd_frame_tx #(.GAP_CYCLES(5), .TIMEOUT_CYCLES(20), .CNT_W(16)) u_gap (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_dir(cmd_dir),
        .cmd_layer(cmd_layer), .cmd_slot(cmd_slot), .cmd_ready(cmd_ready_b),
        .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_done(tx_done_b), .busy(busy_b),
        .frame_done(frame_done_b), .frame_err(frame_err_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] cap_byte[8];
    int         cap_start[8];
    int         cap_done[8];
    int         cap_n, cap_fd, cap_fe, cap_end_cyc;
    logic [7:0] exp_b[8];

    // Starts a command; returns at #1 after the accepting edge.
    task automatic issue(input logic d, input logic [1:0] l, input logic [1:0] s, input bit hold);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_layer = l;
        cmd_slot  = s;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Observes from the current cycle, acking the first n_ack bytes ack_delay clocks after tx_start.
    task automatic collect(input int ack_delay, input int n_ack, input int abort_idx);
        int ack_cyc;
        bit fin;
        ack_cyc = -1;
        fin = 1'b0;
        cap_n = 0; cap_fd = 0; cap_fe = 0; cap_end_cyc = -1;
        for (int k = 0; k < 2000 && !fin; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            tx_done = 1'b0;
            if (tx_start) begin
                if (cap_n < 8) begin
                    cap_byte[cap_n]  = tx_data;
                    cap_start[cap_n] = cyc;
                end
                if (cap_n < n_ack) ack_cyc = cyc + ack_delay;
                if (cap_n == abort_idx) fin = 1'b1;
                cap_n++;
            end
            if (cyc == ack_cyc) begin
                tx_done = 1'b1;
                if (cap_n >= 1 && cap_n <= 8) cap_done[cap_n-1] = cyc;
            end
            if (frame_done) begin cap_fd++; fin = 1'b1; cap_end_cyc = cyc; end
            if (frame_err)  begin cap_fe++; fin = 1'b1; cap_end_cyc = cyc; end
        end
        if (!fin) $display("FAIL collect_timeout no frame end within budget");
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL rst_pulses got=%b%b exp=00", frame_done, frame_err); end
        checks++; if (cmd_ready_b !== 1'b1 || tx_data_b !== 8'h00) begin
            failures++; $display("FAIL rst_gap_inst got=%b/%h exp=1/00", cmd_ready_b, tx_data_b); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_frame();
        int t_acc;
        exp_b = '{8'h58, 8'h50, 8'h53, 8'h44, 8'h53, 8'h43, 8'h30, 8'h34};
        issue(1'b0, 2'd2, 2'd3, 1'b0);
        t_acc = cyc;
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL t1_accept busy/ready got=%b/%b exp=1/0", busy, cmd_ready); end
        collect(10, 8, 8);
        checks++; if (cap_n !== 8) begin failures++; $display("FAIL t1_count got=%0d exp=8", cap_n); end
        checks++; if (cap_start[0] !== t_acc) begin
            failures++; $display("FAIL t1_first_start got=%0d exp=%0d", cap_start[0], t_acc); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_byte[i] !== exp_b[i]) begin
                failures++; $display("FAIL t1_byte%0d got=%h exp=%h", i, cap_byte[i], exp_b[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            checks++; if (cap_start[i+1] - cap_done[i] !== 1) begin
                failures++; $display("FAIL t1_spacing%0d got=%0d exp=1", i, cap_start[i+1] - cap_done[i]); end
        end
        checks++; if (cap_fd !== 1 || cap_fe !== 0) begin
            failures++; $display("FAIL t1_pulses got=%0d/%0d exp=1/0", cap_fd, cap_fe); end
        checks++; if (cap_end_cyc !== cap_done[7] + 1) begin
            failures++; $display("FAIL t1_done_time got=%0d exp=%0d", cap_end_cyc, cap_done[7] + 1); end
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL t1_idle got=%b%b%b exp=100", cmd_ready, busy, frame_done); end
    endtask

    task automatic test_fetch_gap();
        issue(1'b1, 2'd3, 2'd0, 1'b0);
        collect(4, 8, 8);
        checks++; if (cap_byte[4] !== 8'h46 || cap_byte[5] !== 8'h44 || cap_byte[7] !== 8'h31) begin
            failures++; $display("FAIL t2_fetch_bytes got=%h,%h,%h exp=46,44,31", cap_byte[4], cap_byte[5], cap_byte[7]); end
        checks++; if (cap_fd !== 1) begin failures++; $display("FAIL t2_fetch_done got=%0d exp=1", cap_fd); end
        @(posedge clk); #1;
        sel = 1'b1;
        issue(1'b1, 2'd3, 2'd0, 1'b0);
        collect(3, 8, 8);
        checks++; if (cap_n !== 8 || cap_fd !== 1) begin
            failures++; $display("FAIL t2_gap_frame got=%0d/%0d exp=8/1", cap_n, cap_fd); end
        checks++; if (cap_byte[0] !== 8'h58 || cap_byte[4] !== 8'h46 || cap_byte[5] !== 8'h44 || cap_byte[7] !== 8'h31) begin
            failures++; $display("FAIL t2_gap_bytes got=%h,%h,%h,%h exp=58,46,44,31", cap_byte[0], cap_byte[4], cap_byte[5], cap_byte[7]); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (cap_start[i+1] - cap_done[i] !== 6) begin
                failures++; $display("FAIL t2_gap_spacing%0d got=%0d exp=6", i, cap_start[i+1] - cap_done[i]); end
        end
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic test_timeout();
        exp_b = '{8'h58, 8'h50, 8'h53, 8'h44, 8'h46, 8'h41, 8'h30, 8'h32};
        issue(1'b0, 2'd1, 2'd2, 1'b0);
        collect(5, 2, 8);
        checks++; if (cap_n !== 3) begin failures++; $display("FAIL t3_count got=%0d exp=3", cap_n); end
        checks++; if (cap_fe !== 1 || cap_fd !== 0) begin
            failures++; $display("FAIL t3_pulses got=err%0d/done%0d exp=1/0", cap_fe, cap_fd); end
        checks++; if (cap_end_cyc !== cap_start[2] + 20) begin
            failures++; $display("FAIL t3_err_time got=%0d exp=%0d", cap_end_cyc - cap_start[2], 20); end
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL t3_idle got=%b%b%b exp=100", cmd_ready, busy, frame_err); end
        checks++; if (tx_data !== 8'h53) begin failures++; $display("FAIL t3_data_kept got=%h exp=53", tx_data); end
        issue(1'b1, 2'd0, 2'd1, 1'b0);
        collect(2, 8, 8);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_byte[i] !== exp_b[i]) begin
                failures++; $display("FAIL t3_retry_byte%0d got=%h exp=%h", i, cap_byte[i], exp_b[i]); end
        end
        checks++; if (cap_fd !== 1 || cap_fe !== 0) begin
            failures++; $display("FAIL t3_retry_pulses got=%0d/%0d exp=1/0", cap_fd, cap_fe); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int extra;
        issue(1'b0, 2'd0, 2'd0, 1'b1);
        collect(2, 8, 8);
        checks++; if (cap_n !== 8 || cap_fd !== 1) begin
            failures++; $display("FAIL t4_first got=%0d/%0d exp=8/1", cap_n, cap_fd); end
        checks++; if (cap_byte[4] !== 8'h53 || cap_byte[5] !== 8'h41 || cap_byte[7] !== 8'h31) begin
            failures++; $display("FAIL t4_bytes got=%h,%h,%h exp=53,41,31", cap_byte[4], cap_byte[5], cap_byte[7]); end
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || tx_start !== 1'b0) begin
            failures++; $display("FAIL t4_ready got=%b/%b exp=1/0", cmd_ready, tx_start); end
        @(posedge clk); #1;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h58 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL t4_restart got=%b/%h/%b exp=1/58/0", tx_start, tx_data, cmd_ready); end
        cmd_valid = 1'b0;
        collect(2, 8, 8);
        checks++; if (cap_n !== 8 || cap_fd !== 1) begin
            failures++; $display("FAIL t4_second got=%0d/%0d exp=8/1", cap_n, cap_fd); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (tx_start) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL t4_no_third got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(1'b1, 2'd2, 2'd1, 1'b0);
        collect(3, 8, 5);
        checks++; if (cap_n !== 6) begin failures++; $display("FAIL t5_reached got=%0d exp=6", cap_n); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0) begin
            failures++; $display("FAIL t5_rst_ctrl got=%b%b%b exp=100", cmd_ready, busy, tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL t5_rst_data got=%h exp=00", tx_data); end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (frame_done || frame_err || tx_start) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL t5_quiet got=%0d exp=0", pulses); end
        issue(1'b0, 2'd3, 2'd3, 1'b0);
        collect(2, 8, 8);
        checks++; if (cap_byte[0] !== 8'h58 || cap_byte[5] !== 8'h44 || cap_byte[7] !== 8'h34) begin
            failures++; $display("FAIL t5_restart_bytes got=%h,%h,%h exp=58,44,34", cap_byte[0], cap_byte[5], cap_byte[7]); end
        checks++; if (cap_n !== 8 || cap_fd !== 1) begin
            failures++; $display("FAIL t5_restart_frame got=%0d/%0d exp=8/1", cap_n, cap_fd); end
        @(posedge clk); #1;
    endtask

    task automatic test_done_ignored();
        int early;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0) begin
            failures++; $display("FAIL t6_idle_done got=%b%b%b exp=100", cmd_ready, busy, tx_start); end
        issue(1'b0, 2'd1, 2'd0, 1'b0);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h58) begin
            failures++; $display("FAIL t6_first got=%b/%h exp=1/58", tx_start, tx_data); end
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            if (tx_start) early++;
            @(posedge clk); #1;
        end
        checks++; if (early !== 0) begin failures++; $display("FAIL t6_same_cycle got=%0d exp=0", early); end
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h50) begin
            failures++; $display("FAIL t6_second got=%b/%h exp=1/50", tx_start, tx_data); end
        collect(2, 8, 8);
        checks++; if (cap_n !== 7 || cap_byte[0] !== 8'h50 || cap_byte[4] !== 8'h42 || cap_byte[6] !== 8'h31) begin
            failures++; $display("FAIL t6_rest got=%0d/%h/%h/%h exp=7/50/42/31", cap_n, cap_byte[0], cap_byte[4], cap_byte[6]); end
        checks++; if (cap_fd !== 1 || cap_fe !== 0) begin
            failures++; $display("FAIL t6_pulses got=%0d/%0d exp=1/0", cap_fd, cap_fe); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_store_frame();
        test_fetch_gap();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_done_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_frame_tx.md
Name: cmd_frame_tx

Overview:
Serialises one storage-cabinet voice/command frame onto the UART transmit byte interface. It is the transmit-side counterpart of the ASCII command-frame receiver. It takes one parallel command (store/fetch, layer A–D, slot 1–4) and emits the 8-byte ASCII frame "XPSD" + {S|F} + {A..D} + "0" + {1..4}. Each byte is handed to the UART byte transmitter with a start/done handshake. It sits between control logic and the UART TX serializer.

Parameters:
GAP_CYCLES, 0, idle clocks inserted between a byte's tx_done and the next tx_start (0 = back-to-back).
TIMEOUT_CYCLES, 50000, maximum clocks to wait for tx_done after tx_start before the frame is aborted (must be ≥2).
CNT_W, 16, width of the shared gap/timeout counter (must hold max(GAP_CYCLES, TIMEOUT_CYCLES)).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command request, qualified by cmd_ready
cmd_dir  input  1  0 = store ('S'), 1 = fetch ('F')
cmd_layer  input  2  0..3 → 'A'..'D'
cmd_slot  input  2  0..3 → '1'..'4'
cmd_ready  output  1  block idle, command can be accepted
tx_data  output  8  byte presented to the UART transmitter
tx_start  output  1  one-clock pulse requesting transmission of tx_data
tx_done  input  1  one-clock pulse from the UART transmitter, byte finished
busy  output  1  frame in progress
frame_done  output  1  one-clock pulse, all 8 bytes acknowledged
frame_err  output  1  one-clock pulse, timeout abort

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, byte index = 0, counter = 0.
  - cmd_ready = 1, tx_data = 8'h00; tx_start, busy, frame_done, frame_err = 0.
  - Reset mid-frame aborts immediately. No frame_err is issued.
- All outputs are registered. Byte table by index:
  - 0:'X'(58h), 1:'P'(50h), 2:'S'(53h), 3:'D'(44h)
  - 4: cmd_dir ? 'F'(46h) : 'S'(53h)
  - 5: 41h + cmd_layer
  - 6: '0'(30h)
  - 7: 31h + cmd_slot
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at edge T: latch dir/layer/slot, index = 0, go to SEND, cmd_ready = 0, busy = 1.
  - cmd_valid while not IDLE is ignored. It is not queued.
- SEND (one cycle):
  - tx_data = table[index], tx_start = 1 for exactly one clock, counter = 0, go to WAIT.
  - The first tx_start/tx_data = 58h is visible in cycle T+1.
- WAIT:
  - tx_start = 0. tx_data holds its value.
  - tx_done is sampled only in WAIT. tx_done in the same cycle as tx_start is ignored.
  - On tx_done with index == 7: go to DONE.
  - On tx_done with index < 7: index++, then:
    - GAP_CYCLES == 0: go directly to SEND, so the next tx_start comes 1 clock after tx_done.
    - Otherwise: go to GAP with counter = 0.
  - Without tx_done: counter++. When counter reaches TIMEOUT_CYCLES−1 and tx_done is still absent, go to ERR.
  - tx_done on the same edge as the timeout wins, and the byte counts as sent.
- GAP: counter++. When counter == GAP_CYCLES−1, go to SEND.
- DONE (one cycle):
  - frame_done = 1, then go to IDLE.
  - cmd_ready = 1 and busy = 0 from the following cycle.
- ERR (one cycle):
  - frame_err = 1, then go to IDLE. Latched fields are discarded and tx_data is kept.
- frame_done and frame_err are mutually exclusive. Each pulses once per frame at most.
- tx_done pulses received in IDLE, SEND, GAP, DONE or ERR are ignored.

Test Plan:
1. Reset, then cmd_valid with dir=0, layer=2, slot=3, GAP=0; bench acks each tx_start after 10 clocks → tx_data sequence 58,50,53,44,53,43,30,34; 8 tx_start pulses; one frame_done; cmd_ready returns to 1.
2. Fetch command dir=1, layer=3, slot=0 → bytes 4,5,7 are 46h, 44h, 31h. Repeat with GAP_CYCLES=5 → exactly 6 clocks from each tx_done edge to the next tx_start.
3. TIMEOUT_CYCLES=20; bench withholds tx_done after byte 2 → frame_err pulses 20 clocks after the third tx_start; no frame_done; cmd_ready = 1 on the next cycle; a new command then transmits a full frame correctly.
4. cmd_valid held high throughout a frame → only one frame is sent; the second frame's first tx_start appears one clock after cmd_ready re-asserts.
5. rst_n low during WAIT of byte 5 → all outputs return to reset values on the next edge; no frame_done or frame_err; the next command restarts at 'X'.
6. tx_done asserted on the same cycle as tx_start, and also in IDLE → ignored; the index does not advance.
